// File: rtl/fast_square_bb_core.sv
// fast_square_bb_core
// Integrate-and-dump for the fast-square anchor receive path. Complex 16-bit
// ADC samples are summed into saturating accumulators while `record` is high.
// Each `freq_step` dumps a 16-bit slice of the sum as one I/Q result with a
// one-cycle strobe, clears the sum and advances the anchor slot counter.
//
// Ports:
//   clock            system clock, all registers rise on posedge
//   reset            async active-high clear (controller rx_reset)
//   ext_reset        async active-high clear, same effect as reset
//   freq_step        single-cycle dump/advance request
//   record           level, accumulate samples while high
//   i_in, q_in       signed 16-bit samples, one per clock
//   data_out_strobe  one-cycle pulse when i_out/q_out carry a new result
//   i_out, q_out     signed 16-bit result, held between strobes
//   mod_counter      current anchor slot, 0..NUM_SLOTS-1
module fast_square_bb_core #(
  parameter int NUM_SLOTS = 5,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_SHIFT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ext_reset,
  input  logic               freq_step,
  input  logic               record,
  input  logic signed [15:0] i_in,
  input  logic signed [15:0] q_in,
  output logic               data_out_strobe,
  output logic signed [15:0] i_out,
  output logic signed [15:0] q_out,
  output logic [2:0]         mod_counter
);

  // Both reset sources clear everything, so they share one async net.
  logic rst;
  assign rst = reset | ext_reset;

  // Widen a sample to the guard-bit sum width, preserving sign.
  function automatic logic signed [ACC_WIDTH:0] sext_sample(
    input logic signed [15:0] x
  );
    return (ACC_WIDTH+1)'(x);
  endfunction

  // Clamp a one-bit-wider sum back into the accumulator range. Overflow is
  // visible as disagreement between the guard bit and the accumulator MSB;
  // the guard bit then carries the true sign of the result.
  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(
    input logic signed [ACC_WIDTH:0] s
  );
    logic signed [ACC_WIDTH-1:0] r;
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
      r = s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                       : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      r = s[ACC_WIDTH-1:0];
    end
    return r;
  endfunction

  // Wrapping slot increment.
  function automatic logic [2:0] next_slot(input logic [2:0] cur);
    return (cur == 3'(NUM_SLOTS-1)) ? 3'd0 : cur + 3'd1;
  endfunction

  // ---------------- stage 1: input capture ----------------
  logic signed [15:0] x_i_p1, x_q_p1;
  logic               rec_p1, step_p1;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      x_i_p1  <= '0;
      x_q_p1  <= '0;
      rec_p1  <= 1'b0;
      step_p1 <= 1'b0;
    end else begin
      x_i_p1  <= i_in;
      x_q_p1  <= q_in;
      rec_p1  <= record;
      step_p1 <= freq_step;
    end
  end

  // ---------------- stage 2: accumulate / dump ----------------
  logic signed [ACC_WIDTH-1:0] acc_i, acc_q;
  logic signed [ACC_WIDTH:0]   sum_i_p2, sum_q_p2;
  logic signed [ACC_WIDTH-1:0] sat_i_p2, sat_q_p2;

  // The sample captured alongside a dump request is folded into the dumped
  // value, so the same expression serves both accumulate and dump.
  always_comb begin
    sum_i_p2 = sext_acc(acc_i) + (rec_p1 ? sext_sample(x_i_p1) : '0);
    sum_q_p2 = sext_acc(acc_q) + (rec_p1 ? sext_sample(x_q_p1) : '0);
    sat_i_p2 = sat_acc(sum_i_p2);
    sat_q_p2 = sat_acc(sum_q_p2);
  end

  function automatic logic signed [ACC_WIDTH:0] sext_acc(
    input logic signed [ACC_WIDTH-1:0] a
  );
    return {a[ACC_WIDTH-1], a};
  endfunction

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      acc_i           <= '0;
      acc_q           <= '0;
      i_out           <= '0;
      q_out           <= '0;
      data_out_strobe <= 1'b0;
      mod_counter     <= '0;
    end else if (step_p1) begin
      acc_i           <= '0;
      acc_q           <= '0;
      // Plain truncation of the selected slice; no rounding.
      i_out           <= sat_i_p2[OUT_SHIFT+15:OUT_SHIFT];
      q_out           <= sat_q_p2[OUT_SHIFT+15:OUT_SHIFT];
      data_out_strobe <= 1'b1;
      mod_counter     <= next_slot(mod_counter);
    end else begin
      data_out_strobe <= 1'b0;
      if (rec_p1) begin
        acc_i <= sat_i_p2;
        acc_q <= sat_q_p2;
      end
    end
  end

endmodule

// File: tb/tb_fast_square_bb_core.sv
module tb_fast_square_bb_core;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               ext_reset = 1'b0;
  logic               freq_step = 1'b0;
  logic               record = 1'b0;
  logic signed [15:0] i_in = '0;
  logic signed [15:0] q_in = '0;
  logic               data_out_strobe;
  logic signed [15:0] i_out, q_out;
  logic [2:0]         mod_counter;

  int n_tests = 0;
  int n_fail  = 0;

  fast_square_bb_core #(.NUM_SLOTS(5), .ACC_WIDTH(32), .OUT_SHIFT(16)) dut (
    .clock(clock), .reset(reset), .ext_reset(ext_reset),
    .freq_step(freq_step), .record(record), .i_in(i_in), .q_in(q_in),
    .data_out_strobe(data_out_strobe), .i_out(i_out), .q_out(q_out),
    .mod_counter(mod_counter)
  );

  always #5 clock = ~clock;

  // Reference model: plain integer sums clamped to the 32-bit range, the
  // dumped value is the floor of sum / 2^16, results appear one edge after
  // the edge that sampled the step request.
  longint     m_sum_i, m_sum_q;
  bit         m_pend;
  logic [15:0] m_pend_i, m_pend_q;
  logic       exp_strobe;
  logic [15:0] exp_i, exp_q;
  int         exp_cnt;

  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  task automatic model_clear();
    m_sum_i = 0; m_sum_q = 0; m_pend = 0;
    m_pend_i = '0; m_pend_q = '0;
    exp_strobe = 0; exp_i = '0; exp_q = '0; exp_cnt = 0;
  endtask

  // Drive one cycle of inputs, let one posedge pass, update the model.
  task automatic tick(input bit rec, input bit step, input int si, input int sq);
    longint d;
    record = rec; freq_step = step; i_in = 16'(si); q_in = 16'(sq);
    @(posedge clock); #1;
    exp_strobe = m_pend;
    if (m_pend) begin
      exp_i = m_pend_i; exp_q = m_pend_q;
      exp_cnt = (exp_cnt + 1) % 5;
    end
    if (rec) begin
      m_sum_i = clamp32(m_sum_i + longint'(si));
      m_sum_q = clamp32(m_sum_q + longint'(sq));
    end
    m_pend = step;
    if (step) begin
      d = m_sum_i >>> 16; m_pend_i = 16'(d);
      d = m_sum_q >>> 16; m_pend_q = 16'(d);
      m_sum_i = 0; m_sum_q = 0;
    end
  endtask

  // Pulse reset between edges and realign to just after a posedge.
  task automatic pulse_reset();
    record = 0; freq_step = 0;
    reset = 1; #2; reset = 0;
    model_clear();
    tick(0, 0, 0, 0);
  endtask

  function automatic int rnd_sample();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 32767;
    if (r == 1) return -32768;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic test_reset();
    // outputs during the initial reset
    n_tests++; if (data_out_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_init_strobe got %0b want 0", data_out_strobe); end
    n_tests++; if (i_out !== 16'h0000) begin n_fail++; $display("FAIL reset_init_i got %h want 0000", i_out); end
    n_tests++; if (mod_counter !== 3'd0) begin n_fail++; $display("FAIL reset_init_cnt got %0d want 0", mod_counter); end
    @(posedge clock); #1;
    reset = 0;
    model_clear();
    // make outputs and counter non-zero, then leave a partial sum
    for (int k = 0; k < 4; k++) tick(1, 0, 30000, -30000);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    for (int k = 0; k < 3; k++) tick(1, 0, 20000, 20000);
    // mid-cycle reset: everything must clear before the next edge
    reset = 1; #2;
    n_tests++; if (i_out !== 16'h0000) begin n_fail++; $display("FAIL reset_async_i got %h want 0000", i_out); end
    n_tests++; if (q_out !== 16'h0000) begin n_fail++; $display("FAIL reset_async_q got %h want 0000", q_out); end
    n_tests++; if (mod_counter !== 3'd0) begin n_fail++; $display("FAIL reset_async_cnt got %0d want 0", mod_counter); end
    n_tests++; if (data_out_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_async_strobe got %0b want 0", data_out_strobe); end
    #2; reset = 0;
    model_clear();
    tick(0, 0, 0, 0);
    n_tests++; if (data_out_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_no_strobe got %0b want 0", data_out_strobe); end
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    n_tests++; if (data_out_strobe !== 1'b1) begin n_fail++; $display("FAIL reset_dump_strobe got %0b want 1", data_out_strobe); end
    n_tests++; if (i_out !== 16'h0000 || q_out !== 16'h0000) begin n_fail++; $display("FAIL reset_dump_iq got %h/%h want 0000/0000", i_out, q_out); end
    n_tests++; if (mod_counter !== 3'd1) begin n_fail++; $display("FAIL reset_dump_cnt got %0d want 1", mod_counter); end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 8; k++) tick(1, 0, 16384, -16384);
    tick(0, 1, 0, 0);
    n_tests++; if (data_out_strobe !== 1'b0) begin n_fail++; $display("FAIL basic_early_strobe got %0b want 0", data_out_strobe); end
    tick(0, 0, 0, 0);
    n_tests++; if (data_out_strobe !== 1'b1) begin n_fail++; $display("FAIL basic_strobe got %0b want 1", data_out_strobe); end
    n_tests++; if (i_out !== 16'h0002) begin n_fail++; $display("FAIL basic_i got %h want 0002", i_out); end
    n_tests++; if (q_out !== 16'hFFFE) begin n_fail++; $display("FAIL basic_q got %h want fffe", q_out); end
    tick(0, 0, 0, 0);
    n_tests++; if (data_out_strobe !== 1'b0) begin n_fail++; $display("FAIL basic_strobe_width got %0b want 0", data_out_strobe); end
    n_tests++; if (i_out !== 16'h0002) begin n_fail++; $display("FAIL basic_hold_i got %h want 0002", i_out); end
  endtask

  task automatic test_same_cycle();
    for (int k = 0; k < 3; k++) tick(1, 0, 32767, 0);
    tick(1, 1, 32767, 0);
    tick(0, 0, 0, 0);
    n_tests++; if (data_out_strobe !== 1'b1) begin n_fail++; $display("FAIL same_strobe got %0b want 1", data_out_strobe); end
    n_tests++; if (i_out !== 16'h0001) begin n_fail++; $display("FAIL same_i got %h want 0001", i_out); end
    n_tests++; if (q_out !== 16'h0000) begin n_fail++; $display("FAIL same_q got %h want 0000", q_out); end
  endtask

  task automatic test_slot_wrap();
    int seq [6] = '{1, 2, 3, 4, 0, 1};
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
      n_tests++; if (data_out_strobe !== 1'b1) begin n_fail++; $display("FAIL wrap_strobe[%0d] got %0b want 1", k, data_out_strobe); end
      n_tests++; if (mod_counter !== 3'(seq[k])) begin n_fail++; $display("FAIL wrap_cnt[%0d] got %0d want %0d", k, mod_counter, seq[k]); end
      tick(0, 0, 0, 0);
      n_tests++; if (data_out_strobe !== 1'b0) begin n_fail++; $display("FAIL wrap_gap[%0d] got %0b want 0", k, data_out_strobe); end
    end
  endtask

  task automatic test_back_to_back();
    tick(1, 0, 1000, -2000);
    tick(1, 0, 70000 - 65536, 3);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    for (int k = 0; k < 12; k++) begin
      tick(1, 1, rnd_sample(), rnd_sample());
      n_tests++; if (data_out_strobe !== exp_strobe) begin n_fail++; $display("FAIL b2b_strobe[%0d] got %0b want %0b", k, data_out_strobe, exp_strobe); end
      n_tests++; if (i_out !== exp_i || q_out !== exp_q) begin n_fail++; $display("FAIL b2b_iq[%0d] got %h/%h want %h/%h", k, i_out, q_out, exp_i, exp_q); end
      n_tests++; if (mod_counter !== 3'(exp_cnt)) begin n_fail++; $display("FAIL b2b_cnt[%0d] got %0d want %0d", k, mod_counter, exp_cnt); end
    end
    // back-to-back with nothing recorded in between must give zero
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    n_tests++; if (data_out_strobe !== 1'b1 || i_out !== 16'h0000 || q_out !== 16'h0000) begin n_fail++; $display("FAIL b2b_empty got %0b %h/%h want 1 0000/0000", data_out_strobe, i_out, q_out); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, rnd_sample(), rnd_sample());
      n_tests++;
      if (data_out_strobe !== exp_strobe || i_out !== exp_i || q_out !== exp_q || mod_counter !== 3'(exp_cnt)) begin
        n_fail++;
        $display("FAIL random[%0d] got %0b %h/%h c%0d want %0b %h/%h c%0d", k, data_out_strobe, i_out, q_out, mod_counter, exp_strobe, exp_i, exp_q, exp_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    pulse_reset();
    for (int k = 0; k < 70000; k++) tick(1, 0, 32767, -32768);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    n_tests++; if (data_out_strobe !== 1'b1) begin n_fail++; $display("FAIL sat_strobe got %0b want 1", data_out_strobe); end
    n_tests++; if (i_out !== 16'h7FFF) begin n_fail++; $display("FAIL sat_i got %h want 7fff", i_out); end
    n_tests++; if (q_out !== 16'h8000) begin n_fail++; $display("FAIL sat_q got %h want 8000", q_out); end
  endtask

  task automatic test_ext_reset();
    pulse_reset();
    tick(0, 1, 0, 0);
    for (int k = 0; k < 4; k++) tick(1, 0, 25000, -25000);
    // one-cycle ext_reset spanning a clock edge, reset itself stays low
    record = 1; i_in = 16'sd25000; q_in = -16'sd25000;
    ext_reset = 1; #1;
    n_tests++; if (i_out !== 16'h0000 || q_out !== 16'h0000 || mod_counter !== 3'd0) begin n_fail++; $display("FAIL ext_async got %h/%h c%0d want 0000/0000 c0", i_out, q_out, mod_counter); end
    @(posedge clock); #1;
    ext_reset = 0;
    model_clear();
    tick(0, 0, 0, 0);
    n_tests++; if (data_out_strobe !== 1'b0) begin n_fail++; $display("FAIL ext_no_strobe got %0b want 0", data_out_strobe); end
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    n_tests++; if (data_out_strobe !== 1'b1 || i_out !== 16'h0000 || q_out !== 16'h0000) begin n_fail++; $display("FAIL ext_dump got %0b %h/%h want 1 0000/0000", data_out_strobe, i_out, q_out); end
    n_tests++; if (mod_counter !== 3'd1) begin n_fail++; $display("FAIL ext_cnt got %0d want 1", mod_counter); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_same_cycle();
    test_slot_wrap();
    test_back_to_back();
    test_random();
    test_saturation();
    test_ext_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
